spi_slave_tx_mlane: RTL and testbench
=====================================

SPI_SLAVE_TX_MLANE -- requirements
Module: spi_slave_tx_mlane

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; must be a multiple of 4 and at least 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: number of word-buffer entries; must be at least 1.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port cs_ni, input, 1 bit: chip select, already synchronised to clk_i; low means selected.
REQ-006 SHALL have port shift_en_i, input, 1 bit: one-cycle strobe marking the SCLK launch edge.
REQ-007 SHALL have port mode_i, input, 2 bits: lane mode; 00 std, 01 dual, 10 quad, 11 reserved (treated as std).
REQ-008 SHALL have port data_i, input, DATA_WIDTH bits: word to transmit, MSB first.
REQ-009 SHALL have port valid_i, input, 1 bit, and port ready_o, output, 1 bit: valid/ready push handshake into the buffer.
REQ-010 SHALL have port sdo_o, output, 4 bits, and port oen_o, output, 4 bits: lane data and per-lane output enable (oen_o active-low).
REQ-011 SHALL have port done_o, output, 1 bit: pulse on the last beat of each word.
REQ-012 SHALL have port underrun_o, output, 1 bit: pulse when a word boundary is reached with the buffer empty.
REQ-013 SHALL have port level_o, output, clog2(FIFO_DEPTH+1) bits: current buffer occupancy.

Function
REQ-014 Buffer: ready_o = level < FIFO_DEPTH; push on valid_i&&ready_o; no bypass, so a pushed word is poppable the next cycle; push and pop in the same cycle SHALL both occur.
REQ-015 States: IDLE (cs_ni high), WAIT (selected, no word loaded, buffer empty), SHIFT (word loaded), UNDER (shifting zeros).
REQ-016 IDLE->WAIT or IDLE->SHIFT on cs_ni low; from IDLE or WAIT, a non-empty buffer pops into the shift register in the next cycle and the state becomes SHIFT.
REQ-017 Mode SHALL be latched at each load and held for that word; beats per word = DATA_WIDTH/lanes (lanes = 1, 2 or 4).
REQ-018 On shift_en_i in SHIFT/UNDER: shift left by lanes with zero fill; increment the beat counter.
REQ-019 On the last beat: done_o pulses for 1 cycle (SHIFT only); the beat counter clears; if the buffer is non-empty, pop and load in the same cycle (stay SHIFT); else go to UNDER and pulse underrun_o.
REQ-020 UNDER: sdo_o = 0 and beats are counted; at each word boundary reload if the buffer is non-empty, else pulse underrun_o again.
REQ-021 Lane map: std sdo_o[1]=sr[MSB]; dual sdo_o[1:0]=sr[MSB:MSB-1]; quad sdo_o[3:0]=sr[MSB:MSB-3]; unused lanes SHALL be 0.
REQ-022 oen_o: IDLE 1111; otherwise std 1101, dual 1100, quad 0000 from the latched mode; in WAIT, use mode_i.
REQ-023 cs_ni high SHALL override everything in the same cycle: the shift register, beat counter and latched mode clear and the state goes to IDLE.
REQ-024 In IDLE, buffer contents SHALL be preserved and pushes SHALL still be accepted.
REQ-025 shift_en_i SHALL be ignored in IDLE and WAIT.

Reset
REQ-026 On rst_ni low: state IDLE, buffer empty, level_o 0, ready_o 1, sdo_o 0, oen_o 1111, done_o 0, underrun_o 0, latched mode std.
REQ-027 Reset assertion mid-word SHALL abort the word immediately; deassertion SHALL be synchronised externally.

Structure
REQ-028 Package spi_slave_tx_pkg SHALL hold the mode enum (SPI_STD, SPI_DUAL, SPI_QUAD), the state enum and the lane-count function.
REQ-029 The buffer SHALL be sub-module spi_slave_tx_fifo (parameters DATA_WIDTH, FIFO_DEPTH; synchronous; same clock and reset).

Verification
REQ-030 Std push 0xA5A5A5A5, cs low, 32 strobes: sdo_o[1] carries 1,0,1,0,0,1,0,1..., done_o pulses at strobe 32, oen_o 1101.
REQ-031 Quad push 0x12345678, 8 strobes: sdo_o nibbles 1..8, done_o at strobe 8, oen_o 0000.
REQ-032 Dual, two words back-to-back at depth 2: no gap; the second word's MSBs appear on the beat after done_o; level_o goes 2->1->0.
REQ-033 Buffer empty at the boundary: underrun_o pulses, sdo_o 0 for 32 beats, and a word pushed mid-UNDER loads at the next boundary.
REQ-034 cs_ni high at beat 5: oen_o 1111 next cycle, shift register cleared, level_o unchanged; reselect restarts with the next buffered word.
REQ-035 With the buffer full, valid_i held: ready_o 0 and no overwrite; a simultaneous pop and push keeps level_o constant.

Source files
------------

// File: rtl/spi_slave_tx_pkg.sv
// Shared types and helpers for the multi-lane SPI slave transmitter.
// Lane mode decode, lane counts and output-enable patterns live here.
package spi_slave_tx_pkg;

  typedef enum logic [1:0] {
    SPI_STD  = 2'b00,
    SPI_DUAL = 2'b01,
    SPI_QUAD = 2'b10
  } spi_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_UNDER = 2'b11
  } tx_state_e;

  localparam logic [3:0] OEN_OFF  = 4'b1111;
  localparam logic [3:0] OEN_STD  = 4'b1101;
  localparam logic [3:0] OEN_DUAL = 4'b1100;
  localparam logic [3:0] OEN_QUAD = 4'b0000;

  // The reserved encoding 2'b11 behaves as standard single-lane mode.
  function automatic spi_mode_e decode_mode(input logic [1:0] m);
    spi_mode_e r;
    case (m)
      2'b01:   r = SPI_DUAL;
      2'b10:   r = SPI_QUAD;
      default: r = SPI_STD;
    endcase
    return r;
  endfunction

  function automatic int unsigned lane_count(input spi_mode_e m);
    int unsigned n;
    case (m)
      SPI_DUAL: n = 2;
      SPI_QUAD: n = 4;
      default:  n = 1;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] lane_oen(input spi_mode_e m);
    logic [3:0] o;
    case (m)
      SPI_DUAL: o = OEN_DUAL;
      SPI_QUAD: o = OEN_QUAD;
      default:  o = OEN_STD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/spi_slave_tx_fifo.sv
// Synchronous word buffer for the SPI transmitter; a pushed word becomes
// visible at the head on the following cycle (no bypass path).
module spi_slave_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [LW-1:0]         level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [LW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o     = (count_q == LW'(FIFO_DEPTH));
  assign empty_o    = (count_q == '0);
  assign level_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_tx_mlane.sv
// Multi-lane (std/dual/quad) SPI slave transmitter: buffers words and shifts
// them MSB first on each SCLK launch strobe while chip select is low.
module spi_slave_tx_mlane
  import spi_slave_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cs_ni,
  input  logic                  shift_en_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [3:0]            sdo_o,
  output logic [3:0]            oen_o,
  output logic                  done_o,
  output logic                  underrun_o,
  output logic [LW-1:0]         level_o,
  output tx_state_e             state_o
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  spi_mode_e             mode_q, mode_d;

  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         beats_m1;
  logic [DATA_WIDTH-1:0] sr_shifted;
  logic                  last_beat;

  assign ready_o = !fifo_full;
  assign state_o = state_q;

  spi_slave_tx_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (valid_i && ready_o),
    .push_data_i(data_i),
    .pop_i      (pop),
    .pop_data_o (head),
    .level_o    (level_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Beat count and shift distance follow the mode latched at load time.
  always_comb begin
    beats_m1   = CW'(DATA_WIDTH - 1);
    sr_shifted = sr_q << 1;
    case (mode_q)
      SPI_DUAL: begin
        beats_m1   = CW'(DATA_WIDTH / 2 - 1);
        sr_shifted = sr_q << 2;
      end
      SPI_QUAD: begin
        beats_m1   = CW'(DATA_WIDTH / 4 - 1);
        sr_shifted = sr_q << 4;
      end
      default: ;
    endcase
  end

  assign last_beat = (cnt_q == beats_m1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= SPI_STD;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Deselect wins over everything; loads always come from the buffer head.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    pop        = 1'b0;
    done_o     = 1'b0;
    underrun_o = 1'b0;
    if (cs_ni) begin
      state_d = ST_IDLE;
      sr_d    = '0;
      cnt_d   = '0;
      mode_d  = SPI_STD;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            sr_d    = head;
            cnt_d   = '0;
            mode_d  = decode_mode(mode_i);
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: begin
          if (shift_en_i) begin
            if (last_beat) begin
              cnt_d  = '0;
              done_o = (state_q == ST_SHIFT);
              if (!fifo_empty) begin
                pop     = 1'b1;
                sr_d    = head;
                mode_d  = decode_mode(mode_i);
                state_d = ST_SHIFT;
              end else begin
                sr_d       = '0;
                underrun_o = 1'b1;
                state_d    = ST_UNDER;
              end
            end else begin
              sr_d  = sr_shifted;
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  // Lanes only carry data while a real word is loaded; underrun beats drive 0.
  always_comb begin
    sdo_o = '0;
    if (state_q == ST_SHIFT) begin
      case (mode_q)
        SPI_DUAL: sdo_o[1:0] = sr_q[DATA_WIDTH-1 -: 2];
        SPI_QUAD: sdo_o      = sr_q[DATA_WIDTH-1 -: 4];
        default:  sdo_o[1]   = sr_q[DATA_WIDTH-1];
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_IDLE: oen_o = OEN_OFF;
      ST_WAIT: oen_o = lane_oen(decode_mode(mode_i));
      default: oen_o = lane_oen(mode_q);
    endcase
  end

  logic unused_lanes;
  assign unused_lanes = ^lane_count(mode_q);

endmodule

// File: tb/tb_spi_slave_tx_mlane.sv
// Directed bench for spi_slave_tx_mlane: std, quad and dual words, underrun,
// full-buffer backpressure and mid-word deselect.
module tb_spi_slave_tx_mlane;
  import spi_slave_tx_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cs_n;
  logic        shift_en;
  logic [1:0]  mode;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic [3:0]  sdo;
  logic [3:0]  oen;
  logic        done;
  logic        underrun;
  logic [1:0]  level;
  tx_state_e   state;

  int total  = 0;
  int passed = 0;

  spi_slave_tx_mlane #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .cs_ni     (cs_n),
    .shift_en_i(shift_en),
    .mode_i    (mode),
    .data_i    (data),
    .valid_i   (valid),
    .ready_o   (ready),
    .sdo_o     (sdo),
    .oen_o     (oen),
    .done_o    (done),
    .underrun_o(underrun),
    .level_o   (level),
    .state_o   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push_word(input logic [31:0] w);
    valid = 1'b1;
    data  = w;
    tick();
    valid = 1'b0;
  endtask

  function automatic logic [31:0] std_lane(input logic [31:0] w, input int k);
    logic [31:0] b;
    b = (w >> (31 - k)) & 32'h1;
    return b << 1;
  endfunction

  localparam logic [31:0] W_STD   = 32'hA5A5_A5A5;
  localparam logic [31:0] W_UND   = 32'h8000_0001;
  localparam logic [31:0] W_QUAD  = 32'h1234_5678;
  localparam logic [31:0] W_D1    = 32'h9ABC_DEF0;
  localparam logic [31:0] W_D2    = 32'h4321_8765;
  localparam logic [31:0] W_F1    = 32'hFFFF_0000;
  localparam logic [31:0] W_F2    = 32'h0F0F_0F0F;
  localparam logic [31:0] W_F3    = 32'hFFFF_FFFF;
  localparam logic [31:0] W_F4    = 32'h8000_0000;

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; shift_en = 1'b0; mode = 2'b00;
    data = '0; valid = 1'b0;
    tick(); tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_oen", 32'(oen), 32'hF);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Standard word, pushed while deselected.
    push_word(W_STD);
    check("std_level_after_push", 32'(level), 32'd1);
    cs_n = 1'b0; mode = 2'b00;
    tick();
    check("std_state", 32'(state), 32'(ST_SHIFT));
    check("std_oen", 32'(oen), 32'hD);
    check("std_level_after_load", 32'(level), 32'd0);
    for (int k = 0; k < 32; k++) begin
      shift_en = 1'b1;
      #1;
      check("std_sdo", 32'(sdo), std_lane(W_STD, k));
      check("std_done", 32'(done), 32'(k == 31));
      check("std_underrun", 32'(underrun), 32'(k == 31));
      tick();
    end

    // Underrun: zeros for a full word, a mid-underrun push loads at boundary.
    for (int k = 0; k < 32; k++) begin
      shift_en = 1'b1;
      if (k == 10) begin valid = 1'b1; data = W_UND; end
      else valid = 1'b0;
      #1;
      check("und_state", 32'(state), 32'(ST_UNDER));
      check("und_sdo", 32'(sdo), 32'd0);
      check("und_done", 32'(done), 32'd0);
      check("und_underrun", 32'(underrun), 32'd0);
      tick();
    end
    shift_en = 1'b0; valid = 1'b0;
    #1;
    check("und_reload_state", 32'(state), 32'(ST_SHIFT));
    check("und_reload_sdo", 32'(sdo), 32'h2);
    check("und_reload_level", 32'(level), 32'd0);
    cs_n = 1'b1;
    tick();
    check("desel_oen", 32'(oen), 32'hF);
    check("desel_state", 32'(state), 32'(ST_IDLE));

    // WAIT ignores strobes, then a quad word.
    cs_n = 1'b0; mode = 2'b10;
    tick();
    check("wait_state", 32'(state), 32'(ST_WAIT));
    check("wait_oen", 32'(oen), 32'h0);
    for (int k = 0; k < 3; k++) begin
      shift_en = 1'b1;
      #1;
      check("wait_done", 32'(done), 32'd0);
      check("wait_underrun", 32'(underrun), 32'd0);
      tick();
    end
    shift_en = 1'b0;
    push_word(W_QUAD);
    check("wait_hold", 32'(state), 32'(ST_WAIT));
    tick();
    check("quad_state", 32'(state), 32'(ST_SHIFT));
    check("quad_oen", 32'(oen), 32'h0);
    for (int k = 0; k < 8; k++) begin
      shift_en = 1'b1;
      #1;
      check("quad_sdo", 32'(sdo), 32'(k + 1));
      check("quad_done", 32'(done), 32'(k == 7));
      check("quad_underrun", 32'(underrun), 32'(k == 7));
      tick();
    end
    shift_en = 1'b0; cs_n = 1'b1; mode = 2'b00;
    tick();

    // Dual, two words back to back.
    push_word(W_D1);
    push_word(W_D2);
    check("dual_level2", 32'(level), 32'd2);
    check("dual_ready_full", 32'(ready), 32'd0);
    cs_n = 1'b0; mode = 2'b01;
    tick();
    check("dual_level1", 32'(level), 32'd1);
    check("dual_oen", 32'(oen), 32'hC);
    for (int k = 0; k < 16; k++) begin
      shift_en = 1'b1;
      #1;
      check("dual1_sdo", 32'(sdo), (W_D1 >> (30 - 2 * k)) & 32'h3);
      check("dual1_done", 32'(done), 32'(k == 15));
      check("dual1_underrun", 32'(underrun), 32'd0);
      tick();
    end
    check("dual_level0", 32'(level), 32'd0);
    for (int k = 0; k < 16; k++) begin
      shift_en = 1'b1;
      #1;
      check("dual2_sdo", 32'(sdo), (W_D2 >> (30 - 2 * k)) & 32'h3);
      check("dual2_done", 32'(done), 32'(k == 15));
      check("dual2_underrun", 32'(underrun), 32'(k == 15));
      tick();
    end
    shift_en = 1'b0; cs_n = 1'b1; mode = 2'b00;
    tick();

    // Full buffer: held valid must not overwrite; pop+push keeps level.
    push_word(W_F1);
    push_word(W_F2);
    valid = 1'b1; data = W_F3;
    #1;
    check("full_ready", 32'(ready), 32'd0);
    tick();
    check("full_level_a", 32'(level), 32'd2);
    tick();
    check("full_level_b", 32'(level), 32'd2);
    valid = 1'b0;
    cs_n = 1'b0;
    tick();
    check("full_level_after_load", 32'(level), 32'd1);
    for (int k = 0; k < 32; k++) begin
      shift_en = 1'b1;
      if (k == 31) begin valid = 1'b1; data = W_F3; end
      tick();
    end
    valid = 1'b0; shift_en = 1'b0;
    #1;
    check("pushpop_level", 32'(level), 32'd1);
    for (int k = 0; k < 32; k++) begin
      shift_en = 1'b1;
      if (k == 2) begin valid = 1'b1; data = W_F4; end
      else valid = 1'b0;
      #1;
      check("f2_sdo", 32'(sdo), std_lane(W_F2, k));
      check("f2_done", 32'(done), 32'(k == 31));
      check("f2_underrun", 32'(underrun), 32'd0);
      tick();
    end
    valid = 1'b0;
    check("f3_level", 32'(level), 32'd1);

    // Deselect after five beats of the all-ones word, then reselect.
    for (int k = 0; k < 5; k++) begin
      shift_en = 1'b1;
      #1;
      check("f3_sdo", 32'(sdo), 32'h2);
      tick();
    end
    shift_en = 1'b0; cs_n = 1'b1;
    tick();
    check("abort_oen", 32'(oen), 32'hF);
    check("abort_state", 32'(state), 32'(ST_IDLE));
    check("abort_level", 32'(level), 32'd1);
    check("abort_sdo", 32'(sdo), 32'd0);
    cs_n = 1'b0;
    tick();
    check("resel_state", 32'(state), 32'(ST_SHIFT));
    check("resel_sdo_msb", 32'(sdo), 32'h2);
    check("resel_level", 32'(level), 32'd0);
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    #1;
    check("resel_sdo_bit30", 32'(sdo), 32'd0);
    cs_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
